draw_cmd_parser: RTL
====================

# draw_cmd_parser

Command-list consumer of the draw block: pops 32-bit display-list words that the host writes through DRAWCMD into the command FIFO, decodes opcodes and operands, holds frame/draw-area/colour state, and issues one clipped rectangle request per PATBLT to the pixel-write (AXI master) engine. It sits between the command FIFO read port and the fill engine, and reports completion on EODL to the DRAWSTAT/interrupt logic.

## Interface
- CW, 16: coordinate/size field width (upper/lower half of an operand word)
- CMD_TIMEOUT, 1024: cycles allowed with CMD_VALID low inside a command before ERR
- ACLK  in  1  clock
- ARST  in  1  reset. One clock (ACLK); ARST is synchronous and active-high.
- START  in  1  one-cycle pulse from DRAWCTRL bit0
- CMD_DATA  in  32  FIFO head word
- CMD_VALID  in  1  FIFO not empty
- CMD_READY  out  1  pop; a word is consumed when CMD_VALID && CMD_READY
- BLT_VALID  out  1  rectangle request valid
- BLT_READY  in  1  fill engine accepts request
- BLT_VRAMADR  out  32  frame base address
- BLT_STRIDE  out  CW  frame width in pixels
- BLT_X, BLT_Y, BLT_W, BLT_H  out  CW each  clipped rectangle
- BLT_COLOR  out  24  RGB888 foreground colour
- BUSY  out  1  list being processed
- DONE  out  1  one-cycle pulse on EODL accepted
- ERR  out  1  sticky error, cleared by ARST or START

## Operation
- Opcode = CMD_DATA[31:24] of first word; operands follow. 0x20 SETFRAME: VRAMADR, then {WIDTH,HEIGHT}. 0x21 SETDRAWAREA: {POSX,POSY}, {WIDTH,HEIGHT}. 0x23 SETFCOLOR: {8'h0,RGB}. 0x81 PATBLT: {POSX,POSY}, {DSIZEX,DSIZEY}. 0x0F EODL: none. Upper half of operand = X/width, lower = Y/height.
- States: IDLE -> (START) FETCH -> OPND (operand counter 0..1) -> FETCH | CLIP -> ISSUE -> FETCH; EODL -> DONE -> IDLE; unknown opcode or timeout -> ERRST -> IDLE.
- START ignored when BUSY. BUSY = state != IDLE.
- State registers (frame, area, colour) persist across lists; cleared to 0 only by ARST.
- CLIP: x0 = max(PX, AX); x1 = min(PX+DX, AX+AW, FW); same for y. Sums computed in CW+1 bits, no wrap. If x1<=x0 or y1<=y0 the request is dropped (no BLT_VALID), go to FETCH.
- Unknown opcode: ERR set, word consumed, parser stops (IDLE); remaining FIFO words untouched.
- Timeout counter runs only in OPND while CMD_VALID low; reset on every accepted word.

## Timing
- Reset values: CMD_READY 0, BLT_VALID 0, all BLT_* 0, BUSY 0, DONE 0, ERR 0; state IDLE.
- All outputs registered. START at cycle n -> BUSY and CMD_READY high at n+1.
- CMD_READY high only in FETCH/OPND; at most one word per cycle, back-to-back allowed.
- Last PATBLT operand accepted at cycle n -> CLIP at n+1 -> BLT_VALID high at n+2.
- BLT_VALID and BLT_* held stable until BLT_VALID && BLT_READY; CMD_READY low meanwhile. Next opcode pop the cycle after handshake.
- EODL accepted at n -> DONE pulse at n+1, BUSY low at n+2.
- ARST mid-list: returns to IDLE next cycle, drops pending BLT_VALID, no DONE.
- START coincident with ARST: ARST wins.

## Configuration
- DRAW_CMD_CLIP_EN defined: full clipping against draw area and frame as above.
- Undefined: CLIP state passes PX, PY, DX, DY unmodified (area/frame ignored); only DX==0 or DY==0 drops the request; CLIP still takes one cycle so latency is identical.

## Test plan
- Frame 0x20000000 640x480, area 0,0 640x480, colour 0xFF0000, PATBLT 0,0 640x480, EODL -> one BLT {0,0,640,480,FF0000}, DONE once, ERR 0.
- Same setup, colour 0x00FF00, PATBLT 160,120 320x240 -> BLT {160,120,320,240}.
- Area 160,120 320x240, colour 0x0000FF, PATBLT 0,0 640x480 -> BLT {160,120,320,240} (with CLIP_EN); {0,0,640,480} without.
- PATBLT 480,360 320x240 in full area -> BLT {480,360,160,120}; PATBLT 700,0 10x10 -> no BLT, DONE still pulses.
- Opcode 0x55 after SETFCOLOR -> ERR=1, BUSY low, no DONE; new START clears ERR; BLT_READY held low 50 cycles -> BLT_* stable, CMD_READY 0.
- ARST asserted while BLT_VALID high -> all outputs 0 next cycle; following START with random CMD_VALID gaps (<CMD_TIMEOUT) completes correctly.

Source files
------------

// File: rtl/draw_cmd_parser.sv
// draw_cmd_parser: pops display-list words from the command FIFO, decodes
// SETFRAME/SETDRAWAREA/SETFCOLOR/PATBLT/EODL, keeps frame/area/colour state
// and issues one rectangle request per PATBLT to the fill engine.
// Optional feature macro: DRAW_CMD_CLIP_EN (clip PATBLT against draw area and frame).
module draw_cmd_parser #(
    parameter int CW          = 16,
    parameter int CMD_TIMEOUT = 1024
) (
    input  logic          ACLK,
    input  logic          ARST,
    input  logic          START,
    input  logic [31:0]   CMD_DATA,
    input  logic          CMD_VALID,
    output logic          CMD_READY,
    output logic          BLT_VALID,
    input  logic          BLT_READY,
    output logic [31:0]   BLT_VRAMADR,
    output logic [CW-1:0] BLT_STRIDE,
    output logic [CW-1:0] BLT_X,
    output logic [CW-1:0] BLT_Y,
    output logic [CW-1:0] BLT_W,
    output logic [CW-1:0] BLT_H,
    output logic [23:0]   BLT_COLOR,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERR
);

    localparam logic [7:0] OP_SETFRAME    = 8'h20;
    localparam logic [7:0] OP_SETDRAWAREA = 8'h21;
    localparam logic [7:0] OP_SETFCOLOR   = 8'h23;
    localparam logic [7:0] OP_PATBLT      = 8'h81;
    localparam logic [7:0] OP_EODL        = 8'h0F;
    localparam int         TW = (CMD_TIMEOUT > 1) ? $clog2(CMD_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_OPND, S_CLIP, S_ISSUE, S_DONE, S_ERR
    } state_t;

    state_t        state, next_state;
    logic [7:0]    opcode;
    logic          opnd_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [31:0]   vramadr;
    logic [23:0]   fcolor;
    logic [CW-1:0] fw, px, py, dx, dy;
    logic [CW-1:0] clip_x, clip_y, clip_w, clip_h;
    logic          pop, last_opnd, tmo_hit, drop;

    assign pop       = CMD_VALID && CMD_READY;
    assign last_opnd = (opcode == OP_SETFCOLOR) || opnd_cnt;
    assign tmo_hit   = !CMD_VALID && (tmo_cnt == TW'(CMD_TIMEOUT - 1));

`ifdef DRAW_CMD_CLIP_EN
    logic [CW-1:0] fh, ax, ay, aw, ah;
    logic [CW:0]   px_end, py_end, ax_end, ay_end, x1, y1;

    // Intersect the requested rectangle with draw area and frame; sums are CW+1 bits wide.
    always_comb begin
        // NOTE: every output gets a value before any branch, so no latch is inferred;
        // blocking '=' lets x1/y1 be refined step by step within this block.
        clip_x = (px > ax) ? px : ax;
        clip_y = (py > ay) ? py : ay;
        px_end = {1'b0, px} + {1'b0, dx};
        py_end = {1'b0, py} + {1'b0, dy};
        ax_end = {1'b0, ax} + {1'b0, aw};
        ay_end = {1'b0, ay} + {1'b0, ah};
        x1     = (px_end < ax_end) ? px_end : ax_end;
        y1     = (py_end < ay_end) ? py_end : ay_end;
        if ({1'b0, fw} < x1) x1 = {1'b0, fw};
        if ({1'b0, fh} < y1) y1 = {1'b0, fh};
        drop   = (x1 <= {1'b0, clip_x}) || (y1 <= {1'b0, clip_y});
        clip_w = CW'(x1 - {1'b0, clip_x});
        clip_h = CW'(y1 - {1'b0, clip_y});
    end
`else
    // Pass the request through untouched; only an empty size is dropped.
    always_comb begin
        clip_x = px;
        clip_y = py;
        clip_w = dx;
        clip_h = dy;
        drop   = (dx == '0) || (dy == '0);
    end
`endif

    // Next-state decode of the command sequencer.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (START) next_state = S_FETCH;
            S_FETCH: if (pop) begin
                case (CMD_DATA[31:24])
                    OP_SETFRAME, OP_SETDRAWAREA,
                    OP_SETFCOLOR, OP_PATBLT: next_state = S_OPND;
                    OP_EODL:                 next_state = S_DONE;
                    default:                 next_state = S_ERR;
                endcase
            end
            S_OPND:  if (pop) begin
                if (last_opnd) next_state = (opcode == OP_PATBLT) ? S_CLIP : S_FETCH;
            end else if (tmo_hit) begin
                next_state = S_ERR;
            end
            S_CLIP:  next_state = drop ? S_FETCH : S_ISSUE;
            S_ISSUE: if (BLT_READY) next_state = S_FETCH;
            default: next_state = S_IDLE;
        endcase
    end

    // State register and registered control outputs, all derived from next_state.
    always_ff @(posedge ACLK) begin
        // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
        if (ARST) begin
            state     <= S_IDLE;
            CMD_READY <= 1'b0;
            BLT_VALID <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            state     <= next_state;
            CMD_READY <= (next_state == S_FETCH) || (next_state == S_OPND);
            BLT_VALID <= (next_state == S_ISSUE);
            BUSY      <= (next_state != S_IDLE);
            DONE      <= (next_state == S_DONE);
            if (state == S_IDLE && START) ERR <= 1'b0;
            else if (next_state == S_ERR) ERR <= 1'b1;
        end
    end

    // Opcode/operand capture, persistent drawing state and operand timeout.
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            opcode   <= '0;
            opnd_cnt <= 1'b0;
            tmo_cnt  <= '0;
            vramadr  <= '0;
            fcolor   <= '0;
            fw       <= '0;
            px       <= '0;
            py       <= '0;
            dx       <= '0;
            dy       <= '0;
`ifdef DRAW_CMD_CLIP_EN
            fh       <= '0;
            ax       <= '0;
            ay       <= '0;
            aw       <= '0;
            ah       <= '0;
`endif
        end else begin
            if (state == S_OPND && !CMD_VALID) tmo_cnt <= tmo_cnt + TW'(1);
            else tmo_cnt <= '0;
            if (pop && state == S_FETCH) begin
                opcode   <= CMD_DATA[31:24];
                opnd_cnt <= 1'b0;
            end
            if (pop && state == S_OPND) begin
                opnd_cnt <= 1'b1;
                case (opcode)
                    OP_SETFRAME: begin
                        if (!opnd_cnt) vramadr <= CMD_DATA;
                        else begin
                            fw <= CMD_DATA[16 +: CW];
`ifdef DRAW_CMD_CLIP_EN
                            fh <= CMD_DATA[0 +: CW];
`endif
                        end
                    end
                    OP_SETDRAWAREA: begin
`ifdef DRAW_CMD_CLIP_EN
                        if (!opnd_cnt) begin
                            ax <= CMD_DATA[16 +: CW];
                            ay <= CMD_DATA[0 +: CW];
                        end else begin
                            aw <= CMD_DATA[16 +: CW];
                            ah <= CMD_DATA[0 +: CW];
                        end
`endif
                    end
                    OP_SETFCOLOR: fcolor <= CMD_DATA[23:0];
                    OP_PATBLT: begin
                        if (!opnd_cnt) begin
                            px <= CMD_DATA[16 +: CW];
                            py <= CMD_DATA[0 +: CW];
                        end else begin
                            dx <= CMD_DATA[16 +: CW];
                            dy <= CMD_DATA[0 +: CW];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Request registers: loaded in CLIP, held through ISSUE until the handshake.
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            BLT_VRAMADR <= '0;
            BLT_STRIDE  <= '0;
            BLT_X       <= '0;
            BLT_Y       <= '0;
            BLT_W       <= '0;
            BLT_H       <= '0;
            BLT_COLOR   <= '0;
        end else if (state == S_CLIP) begin
            BLT_VRAMADR <= vramadr;
            BLT_STRIDE  <= fw;
            BLT_X       <= clip_x;
            BLT_Y       <= clip_y;
            BLT_W       <= clip_w;
            BLT_H       <= clip_h;
            BLT_COLOR   <= fcolor;
        end
    end

endmodule
